// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
package fwd_pkg;

    localparam int REG_W = 5;

    // ALU operand mux select values (2'd3 is reserved and never driven)
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Destination-register information tracked per pipeline stage
    typedef struct packed {
        logic             valid;
        logic             wreg;
        logic             load;
        logic [REG_W-1:0] dst;
    } stage_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;

    // A stage produces source s when it holds a real register write to s; $0 never matches
    function automatic logic rec_match(input stage_rec_t r, input logic [REG_W-1:0] s);
        return r.valid && r.wreg && (r.dst == s) && (s != '0);
    endfunction

    // Nearest producer wins: EX-stage producer will sit in MEM next cycle, MEM-stage one in WB
    function automatic logic [1:0] pick_sel(input logic used, input logic ex_hit, input logic mem_hit);
        if (!used)
            return FWD_RF;
        else if (ex_hit)
            return FWD_MEM;
        else if (mem_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_stage_rec.sv
// One stage of the shadow pipeline: a resettable destination-register record.
module hz_stage_rec
    import fwd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       hold,
    input  logic       bubble,
    input  stage_rec_t d,
    output stage_rec_t q
);

    // Freeze on hold, otherwise capture either a bubble or the incoming record
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            q <= STAGE_BUBBLE;
        else if (hold)
            q <= q;
        else if (bubble)
            q <= STAGE_BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the five-stage pipeline.
module fwd_hazard_ctrl
    import fwd_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [REG_W-1:0] id_wdst,
    input  logic             id_is_load,
    input  logic             br_flush,
    input  logic             pipe_hold,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall
);

    stage_rec_t id_rec;
    stage_rec_t ex_rec;
    stage_rec_t mem_rec;
    stage_rec_t wb_rec;

    logic       ex_hit_rs;
    logic       ex_hit_rt;
    logic       mem_hit_rs;
    logic       mem_hit_rt;
    logic       ex_bubble;
    logic [1:0] sel_a_next;
    logic [1:0] sel_b_next;

    // Package the ID-stage instruction as the record that will enter EX
    always_comb begin
        id_rec       = STAGE_BUBBLE;
        id_rec.valid = id_valid;
        id_rec.wreg  = id_wreg;
        id_rec.load  = id_is_load;
        id_rec.dst   = id_wdst;
    end

    // Compare each used source against the EX and MEM producers
    always_comb begin
        ex_hit_rs  = id_use_rs && rec_match(ex_rec, id_rs);
        ex_hit_rt  = id_use_rt && rec_match(ex_rec, id_rt);
        mem_hit_rs = id_use_rs && rec_match(mem_rec, id_rs);
        mem_hit_rt = id_use_rt && rec_match(mem_rec, id_rt);
    end

    // Load-use stall: a load in EX feeding the ID instruction; suppressed by hold and flush
    always_comb begin
        stall = id_valid && !pipe_hold && !br_flush &&
                ex_rec.valid && ex_rec.load && (ex_hit_rs || ex_hit_rt);
    end

    // EX gets a bubble whenever the ID instruction cannot advance this edge
    always_comb begin
        ex_bubble  = !(id_valid && !stall && !br_flush);
        sel_a_next = pick_sel(id_use_rs, ex_hit_rs, mem_hit_rs);
        sel_b_next = pick_sel(id_use_rt, ex_hit_rt, mem_hit_rt);
    end

    hz_stage_rec u_ex_rec (
        .clk    (clk),
        .resetn (resetn),
        .hold   (pipe_hold),
        .bubble (ex_bubble),
        .d      (id_rec),
        .q      (ex_rec)
    );

    hz_stage_rec u_mem_rec (
        .clk    (clk),
        .resetn (resetn),
        .hold   (pipe_hold),
        .bubble (1'b0),
        .d      (ex_rec),
        .q      (mem_rec)
    );

    hz_stage_rec u_wb_rec (
        .clk    (clk),
        .resetn (resetn),
        .hold   (pipe_hold),
        .bubble (1'b0),
        .d      (mem_rec),
        .q      (wb_rec)
    );

    // Register the selects so they stay stable for the consumer's whole EX cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (!pipe_hold) begin
            if (ex_bubble) begin
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                fwd_a_sel <= sel_a_next;
                fwd_b_sel <= sel_b_next;
            end
        end
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the five-stage pipeline (IF/ID/EX/MEM/WB). It drives the select inputs of the 32-bit 4:1 operand muxes in front of the ALU and the ID-stage stall. It keeps its own shadow pipeline of destination-register information for EX, MEM and WB. Select values are computed while an instruction is in ID and registered, so they are valid for that instruction's whole EX cycle.

## Interface
Parameters: none (the register index width is fixed at 5).

- clk  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  5  source register A index
- id_rt  in  5  source register B index
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_wreg  in  1  instruction writes a register
- id_wdst  in  5  destination register index (already resolved: rt, rd or 31)
- id_is_load  in  1  instruction is a load; its result is available only in WB
- br_flush  in  1  the ID instruction is squashed (taken branch/jump resolved)
- pipe_hold  in  1  global freeze (memory wait)
- fwd_a_sel  out  2  ALU operand A mux select, registered
- fwd_b_sel  out  2  ALU operand B mux select, registered
- stall  out  1  hold PC and IF/ID, inject a bubble into EX; combinational

## Operation
- Select encoding:
  - 0 = register-file value latched in ID/EX
  - 1 = MEM-stage ALU result
  - 2 = WB-stage result
  - 3 = reserved, never driven
- The register file is write-before-read. An instruction already in WB while the consumer is in ID needs no forwarding.
- Tracking registers: three stage records (ex, mem, wb), each holding {valid, wreg, load, dst}.
- A producer matches source register s when all of these hold: the record is valid, wreg=1, dst==s and s!=0.
- Select for each used source, computed from ID inputs and current records:
  - if the ex record matches → 1 (that producer will be in MEM when the consumer is in EX);
  - else if the mem record matches → 2;
  - else → 0.
  - An unused source always gets 0.
  - The nearest producer wins.
- stall=1 when all of these hold: id_valid, pipe_hold=0, br_flush=0, ex.valid, ex.load, and the ex record matches a used rs or rt.
- Update on each clock edge:
  - pipe_hold=1: all records and selects hold.
  - Otherwise, the records shift: wb←mem, mem←ex.
  - ex←ID info when id_valid & !stall & !br_flush. Otherwise ex becomes a bubble (valid=0) and both selects load 0.
  - Selects load the computed values when ex receives a real instruction.
- Priority: pipe_hold > br_flush > stall.
- After a load-use stall, the consumer re-evaluates next cycle. The load is then in MEM (mem record) and the consumer gets select 2.

## Timing
- Reset (asynchronous, resetn=0): all valid bits 0, fwd_a_sel=0, fwd_b_sel=0; stall is therefore 0.
- Reset asserted mid-stall or mid-hold clears everything immediately. The first edge after release behaves as an empty pipeline.
- Latency:
  - Selects appear one cycle after the consumer is presented in ID.
  - stall is a same-cycle combinational response.
  - A load-use hazard costs exactly one stall cycle.
- Both operands may match different or identical producers independently.
- id_wdst=0 never creates a dependency.
- With pipe_hold=1 and a load-use condition present, stall=0; the stall is raised once the hold drops.

## Structure
- Shared package fwd_pkg:
  - select constants FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2;
  - stage-record field widths and the bubble value.
- One sub-module, hz_stage_rec: a resettable {valid, wreg, load, dst} register with hold and load-bubble controls, instantiated three times.
- Match and select logic stays in the top level.

## Test plan
- add $1 then add $2,$1,$1 back-to-back → next cycle fwd_a_sel=1 and fwd_b_sel=1, stall=0.
- add $3, one nop, then sub $4,$0,$3 → fwd_b_sel=2, fwd_a_sel=0.
- lw $5 then add $6,$5,$7 → stall=1 for exactly one cycle and ex becomes a bubble; next cycle fwd_a_sel=2, fwd_b_sel=0.
- add $8 then add $8 then or $9,$8,$8 → both selects=1, because the nearest producer wins.
- Hazards involving $0 → no forwarding, with either a producer writing $0 or a lw $0 followed by a use → selects 0, stall 0.
- pipe_hold=1 for 3 cycles during the lw/use case → records and selects are frozen and stall=0; one stall cycle follows the release.
- A mid-sequence resetn pulse → selects 0 immediately and no stale forwarding afterwards.
